// File: rtl/bit_serializer_if.sv
// ----------------------------------------------------------------------------
// bit_serializer_if
//   Handshake and serial-output bundle for bit_serializer.
//   Ports / signals:
//     data_in     parallel word from the upstream producer
//     data_valid  upstream word available, held until accepted
//     data_ready  serializer can take a word this cycle
//     out         serial bit toward the pattern detector
//     out_valid   out carries a data bit
//     word_done   pulse on the last bit of a word
//     busy        serializer is not idle
//   master: upstream producer / consumer view; slave: serializer view.
// ----------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             out;
    logic             out_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, out, out_valid, word_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, out, out_valid, word_done, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// ----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial stage feeding the serial pattern detector. Takes
//   WIDTH-bit words over valid/ready and shifts them out one bit per clock,
//   with an optional idle gap after each word and selectable bit order.
//   Ports:
//     clk   system clock, all logic on posedge
//     rst   synchronous active-high reset
//     bus   bit_serializer_if.slave (data_in/data_valid/data_ready in,
//           out/out_valid/word_done/busy out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word in flight, ready for a new word
//   SHIFT | bits of the current word on out, bit_cnt = bits still to go
//   GAP   | idle spacing after a word, gap_cnt counts down to 0
// ----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bit_serializer_if.slave   bus
);
    localparam int                CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [7:0]        GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;
    logic             out_r;
    logic             out_valid_r;
    logic             word_done_r;
    logic             ready;
    logic             accept;
    logic             last_bit;
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             cur_bit;
    logic [WIDTH-1:0] cur_rest;

    assign last_bit = (state == S_SHIFT) && (bit_cnt == '0);

    // Head bit and remaining bits, both for a freshly accepted word and for
    // the word currently being shifted.
    always_comb begin
        load_bit  = 1'b0;
        load_rest = '0;
        cur_bit   = 1'b0;
        cur_rest  = '0;
        if (MSB_FIRST) begin
            load_bit  = bus.data_in[WIDTH-1];
            load_rest = {bus.data_in[WIDTH-2:0], 1'b0};
            cur_bit   = shift_reg[WIDTH-1];
            cur_rest  = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin
            load_bit  = bus.data_in[0];
            load_rest = {1'b0, bus.data_in[WIDTH-1:1]};
            cur_bit   = shift_reg[0];
            cur_rest  = {1'b0, shift_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = !rst && ((state == S_IDLE) || (last_bit && (GAP == 0)));
        accept    = bus.data_valid && ready;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_cnt == '0) begin
                    if (accept)       state_nxt = S_SHIFT;
                    else if (GAP > 0) state_nxt = S_GAP;
                    else              state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == 8'd0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= 8'd0;
            out_r       <= IDLE_LVL;
            out_valid_r <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            if (accept) begin
                out_r       <= load_bit;
                out_valid_r <= 1'b1;
                shift_reg   <= load_rest;
                bit_cnt     <= LAST_LOAD;
            end else if ((state == S_SHIFT) && (bit_cnt != '0)) begin
                out_r       <= cur_bit;
                shift_reg   <= cur_rest;
                bit_cnt     <= bit_cnt - 1'b1;
                // Registered alongside the final bit so both appear together.
                word_done_r <= (bit_cnt == CNT_W'(1));
            end else if (state == S_SHIFT) begin
                out_r       <= IDLE_LVL;
                out_valid_r <= 1'b0;
                gap_cnt     <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt     <= gap_cnt - 1'b1;
            end
        end
    end

    assign bus.data_ready = ready;
    assign bus.out        = out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.word_done  = word_done_r;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_bit_serializer
//   Directed bench for bit_serializer. dut0: WIDTH=8, GAP=0, MSB first.
//   dut1: WIDTH=8, GAP=2, LSB first. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_bit_serializer;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   checks = 0;
    int   errors = 0;

    bit_serializer_if #(.WIDTH(8)) if0 ();
    bit_serializer_if #(.WIDTH(8)) if1 ();

    bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        if0.data_valid = 1'b1;
        if0.data_in = 8'hAA;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (if0.data_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready: got %b expected 0", if0.data_ready);
            end
            checks++;
            if (if0.out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid: got %b expected 0", if0.out_valid);
            end
            checks++;
            if (if0.out !== 1'b0) begin
                errors++; $display("FAIL reset_out: got %b expected 0", if0.out);
            end
            checks++;
            if (if0.word_done !== 1'b0) begin
                errors++; $display("FAIL reset_word_done: got %b expected 0", if0.word_done);
            end
            checks++;
            if (if0.busy !== 1'b0) begin
                errors++; $display("FAIL reset_busy: got %b expected 0", if0.busy);
            end
        end
        rst0 = 1'b0;
        if0.data_valid = 1'b0;
        #1;
        checks++;
        if (if0.data_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", if0.data_ready);
        end
        tick();
        checks++;
        if (if0.out_valid !== 1'b0 || if0.busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_accept: got out_valid=%b busy=%b expected 0 0",
                               if0.out_valid, if0.busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] word;
        word = 8'hA5;
        if0.data_in = word;
        if0.data_valid = 1'b1;
        checks++;
        if (if0.data_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready0: got %b expected 1", if0.data_ready);
        end
        tick();
        if0.data_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick();
            checks++;
            if (if0.out_valid !== 1'b1 || if0.out !== word[8-i]) begin
                errors++; $display("FAIL single_bit%0d: got out=%b valid=%b expected out=%b valid=1",
                                   i, if0.out, if0.out_valid, word[8-i]);
            end
            checks++;
            if (if0.word_done !== (i == 8)) begin
                errors++; $display("FAIL single_done%0d: got %b expected %b", i, if0.word_done, (i == 8));
            end
            checks++;
            if (if0.data_ready !== (i == 8)) begin
                errors++; $display("FAIL single_ready%0d: got %b expected %b", i, if0.data_ready, (i == 8));
            end
        end
        tick();
        checks++;
        if (if0.out_valid !== 1'b0 || if0.out !== 1'b0 || if0.busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got valid=%b out=%b busy=%b expected 0 0 0",
                               if0.out_valid, if0.out, if0.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        int          accepts;
        int          dones;
        stream  = 16'hFF00;
        accepts = 0;
        dones   = 0;
        if0.data_in = 8'hFF;
        if0.data_valid = 1'b1;
        #1;
        if (if0.data_ready === 1'b1 && if0.data_valid === 1'b1) accepts++;
        tick();
        if0.data_in = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            if (k == 9) if0.data_valid = 1'b0;
            checks++;
            if (if0.out_valid !== 1'b1 || if0.out !== stream[16-k]) begin
                errors++; $display("FAIL b2b_bit%0d: got out=%b valid=%b expected out=%b valid=1",
                                   k, if0.out, if0.out_valid, stream[16-k]);
            end
            checks++;
            if (if0.data_ready !== (k == 8 || k == 16)) begin
                errors++; $display("FAIL b2b_ready%0d: got %b expected %b",
                                   k, if0.data_ready, (k == 8 || k == 16));
            end
            if (if0.data_ready === 1'b1 && if0.data_valid === 1'b1) accepts++;
            if (if0.word_done === 1'b1) dones++;
        end
        checks++;
        if (accepts != 2) begin
            errors++; $display("FAIL b2b_accepts: got %0d expected 2", accepts);
        end
        checks++;
        if (dones != 2) begin
            errors++; $display("FAIL b2b_word_done: got %0d expected 2", dones);
        end
        tick();
        checks++;
        if (if0.out_valid !== 1'b0 || if0.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got valid=%b busy=%b expected 0 0", if0.out_valid, if0.busy);
        end
    endtask

    task automatic test_gap();
        logic [7:0] w0;
        logic [7:0] w1;
        w0 = 8'h01;
        w1 = 8'h80;
        if1.data_in = w0;
        if1.data_valid = 1'b1;
        tick();
        // Second word stays offered throughout; it must wait for IDLE.
        if1.data_in = w1;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick();
            checks++;
            if (if1.out_valid !== 1'b1 || if1.out !== w0[i-1]) begin
                errors++; $display("FAIL gap_w0_bit%0d: got out=%b valid=%b expected out=%b valid=1",
                                   i, if1.out, if1.out_valid, w0[i-1]);
            end
            checks++;
            if (if1.data_ready !== 1'b0 || if1.word_done !== (i == 8)) begin
                errors++; $display("FAIL gap_w0_ctl%0d: got ready=%b done=%b expected ready=0 done=%b",
                                   i, if1.data_ready, if1.word_done, (i == 8));
            end
        end
        for (int g = 1; g <= 2; g++) begin
            tick();
            checks++;
            if (if1.out_valid !== 1'b0 || if1.out !== 1'b0 || if1.data_ready !== 1'b0 || if1.busy !== 1'b1) begin
                errors++; $display("FAIL gap_cycle%0d: got valid=%b out=%b ready=%b busy=%b expected 0 0 0 1",
                                   g, if1.out_valid, if1.out, if1.data_ready, if1.busy);
            end
        end
        tick();
        checks++;
        if (if1.data_ready !== 1'b1 || if1.busy !== 1'b0 || if1.out_valid !== 1'b0) begin
            errors++; $display("FAIL gap_idle: got ready=%b busy=%b valid=%b expected 1 0 0",
                               if1.data_ready, if1.busy, if1.out_valid);
        end
        tick();
        if1.data_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick();
            checks++;
            if (if1.out_valid !== 1'b1 || if1.out !== w1[i-1]) begin
                errors++; $display("FAIL gap_w1_bit%0d: got out=%b valid=%b expected out=%b valid=1",
                                   i, if1.out, if1.out_valid, w1[i-1]);
            end
            checks++;
            if (if1.word_done !== (i == 8)) begin
                errors++; $display("FAIL gap_w1_done%0d: got %b expected %b", i, if1.word_done, (i == 8));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] w1;
        w1 = 8'h0F;
        if0.data_in = 8'hF0;
        if0.data_valid = 1'b1;
        tick();
        if0.data_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (if0.out_valid !== 1'b1 || if0.out !== 1'b1) begin
            errors++; $display("FAIL mid_bit3: got out=%b valid=%b expected 1 1", if0.out, if0.out_valid);
        end
        rst0 = 1'b1;
        #1;
        checks++;
        if (if0.data_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready: got %b expected 0", if0.data_ready);
        end
        tick();
        checks++;
        if (if0.out_valid !== 1'b0 || if0.busy !== 1'b0 || if0.word_done !== 1'b0 || if0.out !== 1'b0) begin
            errors++; $display("FAIL mid_after_rst: got valid=%b busy=%b done=%b out=%b expected 0 0 0 0",
                               if0.out_valid, if0.busy, if0.word_done, if0.out);
        end
        rst0 = 1'b0;
        if0.data_in = w1;
        if0.data_valid = 1'b1;
        #1;
        checks++;
        if (if0.data_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release_ready: got %b expected 1", if0.data_ready);
        end
        tick();
        if0.data_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick();
            checks++;
            if (if0.out_valid !== 1'b1 || if0.out !== w1[8-i] || if0.word_done !== (i == 8)) begin
                errors++; $display("FAIL mid_w1_bit%0d: got out=%b valid=%b done=%b expected out=%b valid=1 done=%b",
                                   i, if0.out, if0.out_valid, if0.word_done, w1[8-i], (i == 8));
            end
        end
        tick();
    endtask

    task automatic test_detector();
        logic [2:0] hist;
        int         det_w0;
        int         det_w1;
        hist   = 3'b000;
        det_w0 = 0;
        det_w1 = 0;
        if0.data_in = 8'b0000_0101;
        if0.data_valid = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            if (k == 9) if0.data_valid = 1'b0;
            if (k == 1) begin
                checks++;
                if (if0.data_ready !== 1'b0 || if0.busy !== 1'b1) begin
                    errors++; $display("FAIL det_busy_p1: got ready=%b busy=%b expected 0 1",
                                       if0.data_ready, if0.busy);
                end
            end
            if (k == 2) begin
                checks++;
                if (if0.busy !== 1'b1) begin
                    errors++; $display("FAIL det_busy_p2: got %b expected 1", if0.busy);
                end
            end
            if (if0.out_valid === 1'b1) begin
                hist = {hist[1:0], if0.out};
                if (hist == 3'b101) begin
                    if (k <= 8) det_w0++;
                    else        det_w1++;
                end
            end
        end
        checks++;
        if (det_w0 != 1) begin
            errors++; $display("FAIL det_word0: got %0d pulses expected 1", det_w0);
        end
        checks++;
        if (det_w1 != 1) begin
            errors++; $display("FAIL det_word1: got %0d pulses expected 1", det_w1);
        end
        tick();
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.data_in = 8'h00;
        if0.data_valid = 1'b0;
        if1.data_in = 8'h00;
        if1.data_valid = 1'b0;
        test_reset();
        rst1 = 1'b0;
        tick();
        test_single();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_detector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
